// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared widths, address map, owner tags and cpu fsm states
package vga_fb_pkg;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 90376;
    localparam int IMG_BASE  = 376;
    localparam int STALL_W   = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    typedef enum logic [2:0] {
        C_IDLE = 3'd0,
        C_WAIT = 3'd1,
        C_RD1  = 3'd2,
        C_RD2  = 3'd3,
        C_ACK  = 3'd4
    } cpu_state_t;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: scan-out, processor and RAM signals of the frame-buffer arbiter
interface vga_fb_arbiter_if import vga_fb_pkg::*; ();
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;
    logic [STALL_W-1:0] stall_cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vga_data, vga_valid, cpu_ack, cpu_rdata, cpu_err, stall_cnt,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vga_data, vga_valid, cpu_ack, cpu_rdata, cpu_err, stall_cnt,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_owner_pipe.sv
// fb_owner_pipe: two-stage owner tag delay matching the RAM read latency
module fb_owner_pipe import vga_fb_pkg::*; (
    input  logic   clk,
    input  logic   reset_n,
    input  owner_t tag_in,
    output owner_t tag_out
);
    owner_t s0_q, s0_d, s1_q, s1_d;

    // shift the owner of each bus cycle towards the data return point
    always_comb begin
        s0_d = tag_in;
        s1_d = s0_q;
    end

    // tag registers, cleared so no stale owner survives reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q <= OWN_NONE;
            s1_q <= OWN_NONE;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    assign tag_out = s1_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one frame-buffer RAM between vga scan-out (priority) and a cpu port
module vga_fb_arbiter import vga_fb_pkg::*; (
    input logic             clk,
    input logic             reset_n,
    vga_fb_arbiter_if.slave bus
);
    cpu_state_t         state_q, state_d;
    logic [DATA_W-1:0]  vga_data_q, vga_data_d;
    logic               vga_valid_q, vga_valid_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic               cpu_err_q, cpu_err_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               take, bad, issue;
    owner_t             tag_in, tag_out;

    assign take   = bus.cpu_req && (state_q == C_IDLE || state_q == C_WAIT);
    assign bad    = bus.cpu_addr >= ADDR_W'(MEM_DEPTH);
    assign issue  = take && !bad && !bus.vga_req;
    assign tag_in = bus.vga_req ? OWN_VGA : issue ? OWN_CPU : OWN_NONE;

    fb_owner_pipe u_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // cpu fsm next state, bus mux (vga first) and next values of every registered output
    always_comb begin
        state_d = state_q;
        if (take && bad)
            state_d = C_ACK;
        else if (issue)
            state_d = bus.cpu_we ? C_ACK : C_RD1;
        else if (take)
            state_d = C_WAIT;
        else if (state_q == C_WAIT)
            state_d = C_IDLE;
        else if (state_q == C_RD1)
            state_d = C_RD2;
        else if (state_q == C_RD2)
            state_d = C_ACK;
        else if (state_q == C_ACK)
            state_d = C_IDLE;
        stall_d     = (state_q == C_IDLE && take) ? '0 :
                      (state_q == C_WAIT && take && bus.vga_req && stall_q != '1) ? stall_q + STALL_W'(1) :
                      stall_q;
        mem_addr_d  = bus.vga_req ? bus.vga_addr : issue ? bus.cpu_addr : mem_addr_q;
        mem_we_d    = issue && bus.cpu_we;
        mem_wdata_d = (issue && bus.cpu_we) ? bus.cpu_wdata : mem_wdata_q;
        cpu_ack_d   = state_d == C_ACK;
        cpu_err_d   = take && bad;
        cpu_rdata_d = (take && bad) ? '0 : (state_q == C_RD2) ? bus.mem_rdata : cpu_rdata_q;
        vga_valid_d = tag_out == OWN_VGA;
        vga_data_d  = (tag_out == OWN_VGA) ? bus.mem_rdata : '0;
    end

    // fsm state and all outputs; reset drops any in-flight cpu transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= C_IDLE;
            stall_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_valid_q <= vga_valid_d;
            vga_data_q  <= vga_data_d;
        end
    end

    assign bus.vga_data  = vga_data_q;
    assign bus.vga_valid = vga_valid_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.stall_cnt = stall_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for the frame-buffer arbiter with scheduled and random traffic
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    localparam int NCYC = 2600;

    typedef struct {int due; logic [DATA_W-1:0] data;} vexp_t;
    typedef struct {int due; logic [DATA_W-1:0] rdata; logic err; logic rd; int stall;} cexp_t;
    typedef struct {int due; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} aexp_t;
    typedef struct {int start; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} op_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   acks = 0;

    logic [DATA_W-1:0] ram     [MEM_DEPTH];
    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
    logic              vreq    [NCYC];
    logic [ADDR_W-1:0] vaddr   [NCYC];
    vexp_t vq[$];
    cexp_t cq[$];
    aexp_t aq[$];
    op_t   ops[$];

    vga_fb_arbiter_if bus();

    vga_fb_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_addr < ADDR_W'(MEM_DEPTH)) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end else begin
            bus.mem_rdata <= '0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.vga_data, bus.vga_valid, bus.cpu_ack, bus.cpu_rdata, bus.cpu_err,
                    bus.stall_cnt, bus.mem_addr, bus.mem_we, bus.mem_wdata});
    endfunction

    always @(negedge clk) begin : monitor
        vexp_t v;
        cexp_t c;
        aexp_t a;
        if (bus.cpu_ack) acks++;
        if (vq.size() > 0 && vq[0].due == cyc) begin
            v = vq.pop_front();
            chk("vga_pixel", {bus.vga_valid, bus.vga_data}, {1'b1, v.data});
        end else begin
            chk("vga_idle", {bus.vga_valid, bus.vga_data}, 0);
        end
        if (cq.size() > 0 && cq[0].due == cyc) begin
            c = cq.pop_front();
            chk("cpu_ack_err", {bus.cpu_ack, bus.cpu_err}, {1'b1, c.err});
            if (c.rd) chk("cpu_rdata", bus.cpu_rdata, c.rdata);
            chk("stall_cnt", bus.stall_cnt, c.stall);
        end else begin
            chk("cpu_no_ack", {bus.cpu_ack, bus.cpu_err}, 0);
        end
        if (aq.size() > 0 && aq[0].due == cyc) begin
            a = aq.pop_front();
            if (a.we) chk("mem_write", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, a.addr, a.data});
            else chk("mem_cpu_read", {bus.mem_we, bus.mem_addr}, {1'b0, a.addr});
        end else begin
            chk("mem_we_idle", bus.mem_we, 0);
        end
    end

    task automatic run_sched(input int last);
        int  e, i, a;
        bit  busy;
        op_t op;
        busy = 0;
        a = 0;
        while ((cyc < last || busy || ops.size() > 0) && cyc < NCYC - 40) begin
            e = cyc + 1;
            bus.vga_req  = vreq[e];
            bus.vga_addr = vaddr[e];
            if (vreq[e]) vq.push_back(vexp_t'{e + 2, ref_mem[vaddr[e]]});
            if (busy && e >= a + 2) begin
                busy = 0;
                bus.cpu_req = 1'b0;
            end
            if (!busy && ops.size() > 0 && ops[0].start <= e) begin
                op = ops.pop_front();
                bus.cpu_req   = 1'b1;
                bus.cpu_we    = op.we;
                bus.cpu_addr  = op.addr;
                bus.cpu_wdata = op.wdata;
                busy = 1;
                if (op.addr >= ADDR_W'(MEM_DEPTH)) begin
                    a = e;
                    cq.push_back(cexp_t'{e, '0, 1'b1, 1'b1, 0});
                end else begin
                    i = e;
                    while (i < NCYC - 1 && vreq[i]) i++;
                    a = op.we ? i : i + 2;
                    aq.push_back(aexp_t'{i, op.we, op.addr, op.wdata});
                    cq.push_back(cexp_t'{a, ref_mem[op.addr], 1'b0, !op.we, (i > e) ? i - e - 1 : 0});
                    if (op.we) ref_mem[op.addr] = op.wdata;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.cpu_req = 1'b0;
        bus.vga_req = 1'b0;
    endtask

    initial begin
        int k, n, base, len, start;
        op_t o;
        bus.vga_req = 1'b0;
        bus.vga_addr = '0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        for (k = 0; k < MEM_DEPTH; k++) begin
            ram[k] <= k[7:0];
            ref_mem[k] = k[7:0];
        end
        for (k = 0; k < NCYC; k++) begin
            vreq[k] = 1'b0;
            vaddr[k] = '0;
        end
        for (k = 10; k < 15; k++) begin vreq[k] = 1'b1; vaddr[k] = ADDR_W'(366 + k); end
        for (k = 60; k < 71; k++) begin vreq[k] = 1'b1; vaddr[k] = ADDR_W'(340 + k); end
        for (k = 121; k < 126; k++) begin vreq[k] = 1'b1; vaddr[k] = ADDR_W'(379 + k); end
        ops.push_back(op_t'{30, 1'b1, ADDR_W'(1000), 8'hA5});
        ops.push_back(op_t'{40, 1'b0, ADDR_W'(1000), 8'h00});
        ops.push_back(op_t'{60, 1'b0, ADDR_W'(2000), 8'h00});
        ops.push_back(op_t'{90, 1'b0, ADDR_W'(MEM_DEPTH), 8'h00});
        ops.push_back(op_t'{100, 1'b1, 18'h3FFFF, 8'h5A});
        ops.push_back(op_t'{120, 1'b0, ADDR_W'(3000), 8'h00});
        k = 200;
        while (k < 2200) begin
            len = int'($urandom_range(0, 24));
            base = int'($urandom_range(IMG_BASE, MEM_DEPTH - 30));
            for (int j = 0; j < len && k < 2200; j++) begin
                vreq[k] = 1'b1;
                vaddr[k] = ADDR_W'(base + j);
                k++;
            end
            k += int'($urandom_range(1, 6));
        end
        for (n = 0; n < 70; n++) begin
            o.start = 200 + n * 28;
            o.we = 1'($urandom_range(0, 1));
            o.addr = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(2 ** ADDR_W - 1, MEM_DEPTH))
                                                 : ADDR_W'($urandom_range(0, IMG_BASE - 1));
            o.wdata = 8'($urandom);
            ops.push_back(o);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_sched(2350);
        repeat (4) @(posedge clk);
        #1;

        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = ADDR_W'(1500);
        @(posedge clk);
        #1;
        chk("rd_issue_addr", {bus.mem_we, bus.mem_addr}, {1'b0, ADDR_W'(1500)});
        reset_n = 1'b0;
        #1;
        chk("reset_mid_read", outs(), 0);
        bus.cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n = acks;
        repeat (10) @(posedge clk);
        #1;
        chk("no_ack_after_reset", acks - n, 0);

        start = cyc + 5;
        ops.push_back(op_t'{start, 1'b0, ADDR_W'(1000), 8'h00});
        for (k = start + 3; k < start + 8; k++) begin vreq[k] = 1'b1; vaddr[k] = ADDR_W'(200 + k); end
        run_sched(start + 30);
        repeat (5) @(posedge clk);
        #1;
        chk("vga_queue_drained", vq.size(), 0);
        chk("cpu_queue_drained", cq.size(), 0);
        chk("mem_queue_drained", aq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between two requesters: the VGA scan-out pixel fetch and a processor/loader port.
- VGA fetch has absolute priority. Processor accesses are issued only in cycles where the scan-out is not requesting, i.e. during blanking and outside the image window.
- Sits between vga_generator (address in, pixel colour out) and the image RAM.

Parameters:
ADDR_W, 18, width of all frame-buffer addresses
DATA_W, 8, pixel / data width
MEM_DEPTH, 90376, valid address range 0..MEM_DEPTH-1; image occupies 376..90375
STALL_W, 16, width of processor stall counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
vga_req  in  1  scan-out wants a pixel this cycle (high inside image window)
vga_addr  in  ADDR_W  scan-out pixel address
vga_data  out  DATA_W  fetched pixel, 2 cycles after request
vga_valid  out  1  vga_data carries a fetched pixel
cpu_req  in  1  processor request, held with addr/we/wdata stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  processor address
cpu_wdata  in  DATA_W  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid with cpu_ack (held until next ack)
cpu_err  out  1  pulses with cpu_ack when cpu_addr >= MEM_DEPTH
stall_cnt  out  STALL_W  cycles the current/last cpu request waited for the bus, saturating
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data, valid the cycle after the edge that captures mem_addr

Behaviour:
- Reset, async with reset_n low: all outputs 0, FSM C_IDLE, pipeline tags cleared, stall_cnt 0. An in-flight cpu transaction is dropped and is never acked.
- Bus owner per edge: vga_req=1 -> VGA; otherwise a cpu op in C_IDLE/C_WAIT -> CPU; otherwise idle (mem_we=0, mem_addr held).
- VGA path:
  - Edge k samples vga_req=1: mem_addr<=vga_addr, mem_we<=0, owner tag VGA pushed into a 2-deep pipe.
  - Edge k+2: vga_data<=mem_rdata, vga_valid<=1.
  - When the tag at k+2 is not VGA: vga_valid<=0, vga_data<=0 (black).
  - Fixed 2-cycle latency; back-to-back every cycle with no bubbles.
- CPU FSM:
  - C_IDLE:
    - cpu_req && cpu_addr>=MEM_DEPTH -> C_ACK with err=1, rdata=0, no RAM access.
    - cpu_req && !vga_req -> issue op this edge. Write -> C_ACK; read -> C_RD1.
    - cpu_req && vga_req -> C_WAIT.
  - C_WAIT: stall_cnt increments each cycle vga_req=1. Issue on the first edge with vga_req=0; same transitions as C_IDLE.
  - C_RD1: RAM latency cycle -> C_RD2.
  - C_RD2: cpu_rdata<=mem_rdata -> C_ACK.
  - C_ACK: cpu_ack=1 for exactly one cycle (cpu_err as decided), then C_IDLE.
  - Write ack comes 1 cycle after issue; read ack 3 cycles after issue.
- Handshake:
  - Master drops cpu_req in the cycle after cpu_ack, or keeps it high with a new op.
  - C_IDLE re-samples the request; no op is issued twice.
- Collisions:
  - vga_req rising on the same edge a cpu issue would occur -> VGA wins; cpu goes to/stays in C_WAIT.
  - A cpu read in C_RD1/C_RD2 does not block VGA. The tag pipe routes data by owner.
- stall_cnt: cleared on entry to C_WAIT from C_IDLE, saturates at all-ones, holds its value after ack.
- cpu_addr range check uses unsigned compare at full ADDR_W.

Decomposition:
- Shared package vga_fb_pkg: ADDR_W/DATA_W defaults, MEM_DEPTH, IMG_BASE=376, owner tag encoding (NONE/VGA/CPU), CPU FSM state encoding.
- One natural sub-module, fb_owner_pipe: 2-deep owner-tag shift register with async reset, reused for tag alignment.

Test Plan:
- vga_req high 5 cycles, addrs 376..380, RAM model data = addr[7:0] -> vga_valid high 5 cycles starting 2 cycles later, vga_data 0x78..0x7C, no gaps.
- vga_req=0, cpu write addr 1000 data 0xA5 -> mem_we pulse with addr 1000; cpu_ack 1 cycle after issue; later cpu read 1000 -> cpu_rdata 0xA5, ack 3 cycles after issue, stall_cnt 0.
- cpu read requested while vga_req high for 10 more cycles -> no RAM cpu access during those cycles, stall_cnt=10, issue on first vga_req=0 edge, VGA stream unbroken.
- cpu_addr=90376 (and 0x3FFFF) -> cpu_ack with cpu_err=1, cpu_rdata 0, mem_we never asserted.
- cpu read issued, vga_req rises the next cycle -> cpu_rdata is the cpu address data, vga_data the VGA address data; tags not swapped.
- reset_n pulled low while in C_RD1 -> all outputs 0 immediately, no cpu_ack after release, next request serviced normally.
